// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for the EX-stage div/divu instructions.
// Returns {remainder, quotient}; the result holds while EX keeps start_i asserted.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {IDLE, DIV0, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [64:0] w_q, w_d;
  logic [31:0] d_q, d_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [64:0] shifted;
  logic [32:0] diff;
  logic [31:0] abs_a, abs_b, q_fin, r_fin;

  always_comb begin
    shifted = w_q << 1;
    diff    = shifted[64:32] - {1'b0, d_q};
    abs_a   = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    abs_b   = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    // After 32 steps the partial remainder is below D, so it fits in W[63:32].
    q_fin   = (sgn_q && (s1_q ^ s2_q)) ? (~w_q[31:0] + 32'd1) : w_q[31:0];
    r_fin   = (sgn_q && s1_q) ? (~w_q[63:32] + 32'd1) : w_q[63:32];
  end

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      IDLE: begin
        ready_d  = 1'b0;
        result_d = 64'd0;
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_d = DIV0;
          end else begin
            state_d = BUSY;
            w_d     = {33'd0, abs_a};
            d_d     = abs_b;
            cnt_d   = 6'd0;
            sgn_d   = signed_div_i;
            s1_d    = opdata1_i[31];
            s2_d    = opdata2_i[31];
          end
        end
      end
      DIV0: begin
        state_d  = DONE;
        ready_d  = 1'b1;
        result_d = 64'd0;
      end
      BUSY: begin
        if (annul_i) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end else if (cnt_q == 6'd32) begin
          state_d  = DONE;
          ready_d  = 1'b1;
          result_d = {r_fin, q_fin};
        end else begin
          if (!diff[32]) w_d = {diff, shifted[31:1], 1'b1};
          else           w_d = shifted;
          cnt_d = cnt_q + 6'd1;
        end
      end
      DONE: begin
        if (!start_i) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      w_q      <= 65'd0;
      d_q      <= 32'd0;
      cnt_q    <= 6'd0;
      sgn_q    <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: the driver queues expected results and ready cycles,
// and a negedge monitor checks each result and its timing as the DUT presents it.
module tb_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = 32'd0;
  logic [31:0] opdata2_i = 32'd0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        prev_ready = 1'b0;
  logic [63:0] cur_exp = 64'd0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per ready rising, then watches the held/idle values.
  always @(negedge clk) begin
    if (ready_o === 1'b1 && !prev_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ready: got result 0x%016h with no operation pending", result_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        cur_exp = e.res;
        check("result", result_o, e.res);
        check("latency_cycle", 64'(cyc), 64'(e.cyc));
        $display("[TB] result 0x%016h at cycle %0d", result_o, cyc);
      end
    end else if (ready_o === 1'b1) begin
      check("hold_stable", result_o, cur_exp);
    end else begin
      check("idle_ready", {63'd0, ready_o}, 64'd0);
      check("idle_result_zero", result_o, 64'd0);
    end
    prev_ready = (ready_o === 1'b1);
  end

  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat);
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    sb.push_back('{exp, cyc + lat});
    // Scramble operands after the sampling edge; the result must not change.
    @(negedge clk);
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~s;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ready_o !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: ready_o=%b after 100 cycles, expected 1", name, ready_o);
    end
  endtask

  task automatic run(input string name, input logic s, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] exp, input int lat,
                     input int hold);
    $display("[TB] %s: signed=%0d a=0x%08h b=0x%08h", name, s, a, b);
    start_op(s, a, b, exp, lat);
    wait_ready(name);
    repeat (hold) @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    check({name, "_drop_ready"}, {63'd0, ready_o}, 64'd0);
    check({name, "_drop_result"}, result_o, 64'd0);
  endtask

  initial begin
    #12 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);

    run("divu_100_7",     1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 34, 2);
    run("div_m7_2",       1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 34, 1);
    run("div_7_m2",       1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 34, 1);
    run("div_m7_m2",      1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003, 34, 1);
    run("div_min_m1",     1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 34, 1);
    run("divu_max_1",     1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 34, 1);
    run("divu_min_max",   1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 34, 1);
    run("div_m100_7",     1'b1, 32'hFFFFFF9C,   32'd7,          64'hFFFFFFFE_FFFFFFF2, 34, 1);
    run("divu_1e6_3",     1'b0, 32'd1000000,    32'd3,          64'h00000001_00051615, 34, 1);
    run("divu_5_9",       1'b0, 32'd5,          32'd9,          64'h00000005_00000000, 34, 1);
    run("divu_by_zero",   1'b0, 32'd1234,       32'd0,          64'h0,                  2, 2);
    run("div_by_zero",    1'b1, 32'd1234,       32'd0,          64'h0,                  2, 1);

    // Annul on step 10: E0 is the first edge after start, step k lands on edge E_k.
    $display("[TB] annul at step 10");
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    repeat (40) @(negedge clk);
    check("annul_ready_low", {63'd0, ready_o}, 64'd0);
    run("divu_9_3_after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, 1);

    // Asynchronous reset mid-division, between clock edges.
    $display("[TB] reset at step 20");
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    start_i = 1'b0;
    #1;
    check("rst_mid_ready", {63'd0, ready_o}, 64'd0);
    check("rst_mid_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset while a result is held must clear it without an edge.
    $display("[TB] reset while done");
    start_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);
    wait_ready("done_rst");
    #2 rst = 1'b1;
    start_i = 1'b0;
    #1;
    check("rst_done_ready", {63'd0, ready_o}, 64'd0);
    check("rst_done_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run("divu_100_7_after_rst", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34, 5);

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL pending_results: %0d expected results never presented, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
